// File: rtl/bcd_down_counter_pkg.sv
// Shared types and helpers for the BCD down-counter: FSM state encoding,
// digit width/limit and the per-digit preset clamp.
package bcd_down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2
    } state_t;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Non-decimal nibbles (A-F) are forced to 9 so the counter never holds an illegal digit
    function automatic logic [BCD_W-1:0] clampDigit(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the decrement chain: subtracts the incoming borrow and
// passes a borrow on when the digit wraps from 0 to 9.
module bcd_digit_dec
    import bcd_down_counter_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             borrow,
    output logic [BCD_W-1:0] result,
    output logic             borrowNext
);

    always_comb begin
        result     = digit;
        borrowNext = 1'b0;
        if (borrow) begin
            if (digit == '0) begin
                result     = BCD_MAX;
                borrowNext = 1'b1;
            end else begin
                result = digit - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_down_counter.sv
// Cascadable multi-digit BCD countdown timer with terminal borrow and done pulse.
// Define BCD_DOWN_RELOAD_EN to auto-reload the last preset after each expiry.
module bcd_down_counter
    import bcd_down_counter_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clkEn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   loadVal,
    output logic [4*DIGITS-1:0]   count,
    output logic                  bo,
    output logic                  busy,
    output logic                  done
);

    localparam int W = BCD_W * DIGITS;

    state_t        state;
    logic [W-1:0]  clampVal;
    logic [W-1:0]  decVal;
    logic [DIGITS:0] borrow;
    logic          tick;
    logic          underflow;

`ifdef BCD_DOWN_RELOAD_EN
    logic [W-1:0]  shadow;
`endif

    always_comb begin
        clampVal = '0;
        for (int i = 0; i < DIGITS; i++) begin
            clampVal[i*BCD_W +: BCD_W] = clampDigit(loadVal[i*BCD_W +: BCD_W]);
        end
    end

    assign borrow[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : gDigit
            bcd_digit_dec uDigit (
                .digit      (count[g*BCD_W +: BCD_W]),
                .borrow     (borrow[g]),
                .result     (decVal[g*BCD_W +: BCD_W]),
                .borrowNext (borrow[g+1])
            );
        end
    endgenerate

    // A borrow out of the top digit means count is already zero
    assign underflow = borrow[DIGITS];
    assign tick      = en & clkEn;
    assign bo        = ~|count;
    assign busy      = (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
`ifdef BCD_DOWN_RELOAD_EN
            shadow <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (load) begin
                count <= clampVal;
                state <= (clampVal == '0) ? ZERO : RUN;
`ifdef BCD_DOWN_RELOAD_EN
                shadow <= clampVal;
`endif
            end else if (tick) begin
                case (state)
                    RUN: begin
                        if (underflow) begin
`ifdef BCD_DOWN_RELOAD_EN
                            count <= shadow;
`else
                            state <= ZERO;
`endif
                        end else begin
                            count <= decVal;
                            if (decVal == '0) begin
                                done <= 1'b1;
`ifndef BCD_DOWN_RELOAD_EN
                                state <= ZERO;
`endif
                            end
                        end
                    end
                    ZERO:    count <= '0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed testbench for bcd_down_counter (DIGITS=2): load, clamp, countdown,
// gating, load priority, back-to-back reload and asynchronous reset.
module tb_bcd_down_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clkEn;
    logic       load;
    logic [7:0] loadVal;
    logic [7:0] count;
    logic       bo;
    logic       busy;
    logic       done;

    int vectors;
    int miscompares;

    bcd_down_counter #(.DIGITS(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clkEn   (clkEn),
        .load    (load),
        .loadVal (loadVal),
        .count   (count),
        .bo      (bo),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation timeout");
    end

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; clkEn = 1'b0; load = 1'b0; loadVal = 8'h00;
        #12;
        vectors++;
        if (count !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_count: got %h expected 00", count); end
        vectors++;
        if (bo !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_bo: got %b expected 1", bo); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_countdown();
        logic [7:0] expSeq [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                                    8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        load = 1'b1; loadVal = 8'h12; en = 1'b0; clkEn = 1'b0;
        step();
        load = 1'b0;
        vectors++;
        if (count !== 8'h12) begin miscompares++; $display("[TB] FAIL load_12: got %h expected 12", count); end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_after_load: got %b expected 1", busy); end
        en = 1'b1; clkEn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            vectors++;
            if (count !== expSeq[i]) begin
                miscompares++;
                $display("[TB] FAIL countdown_%0d: got %h expected %h", i, count, expSeq[i]);
            end
            vectors++;
            if (done !== (expSeq[i] == 8'h00)) begin
                miscompares++;
                $display("[TB] FAIL done_%0d: got %b expected %b", i, done, (expSeq[i] == 8'h00));
            end
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_at_zero: got %b expected 0", busy); end
        vectors++;
        if (bo !== 1'b1) begin miscompares++; $display("[TB] FAIL bo_at_zero: got %b expected 1", bo); end
        step();
        vectors++;
        if (count !== 8'h00) begin miscompares++; $display("[TB] FAIL no_wrap: got %h expected 00", count); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL done_one_cycle: got %b expected 0", done); end
        en = 1'b0; clkEn = 1'b0;
    endtask

    task automatic test_clamp();
        logic [7:0] presets [3] = '{8'h3F, 8'hA5, 8'hFF};
        logic [7:0] clamped [3] = '{8'h39, 8'h95, 8'h99};
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load = 1'b1; loadVal = presets[i];
            step();
            vectors++;
            if (count !== clamped[i]) begin
                miscompares++;
                $display("[TB] FAIL clamp_%h: got %h expected %h", presets[i], count, clamped[i]);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_load_priority();
        load = 1'b1; loadVal = 8'h05; en = 1'b0; clkEn = 1'b0;
        step();
        load = 1'b1; loadVal = 8'h20; en = 1'b1; clkEn = 1'b1;
        step();
        vectors++;
        if (count !== 8'h20) begin miscompares++; $display("[TB] FAIL load_priority: got %h expected 20", count); end
        load = 1'b0;
        step();
        vectors++;
        if (count !== 8'h19) begin miscompares++; $display("[TB] FAIL dec_after_load: got %h expected 19", count); end
        en = 1'b0; clkEn = 1'b0;
    endtask

    task automatic test_clken_gate();
        logic       pattern [3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0] expSeq  [3] = '{8'h02, 8'h02, 8'h01};
        load = 1'b1; loadVal = 8'h03; en = 1'b0; clkEn = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clkEn = pattern[i];
            step();
            vectors++;
            if (count !== expSeq[i]) begin
                miscompares++;
                $display("[TB] FAIL clken_%0d: got %h expected %h", i, count, expSeq[i]);
            end
        end
        en = 1'b0; clkEn = 1'b1;
        step();
        vectors++;
        if (count !== 8'h01) begin miscompares++; $display("[TB] FAIL en_hold: got %h expected 01", count); end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL en_hold_busy: got %b expected 1", busy); end
        clkEn = 1'b0;
    endtask

    task automatic test_back_to_back();
        load = 1'b1; loadVal = 8'h01; en = 1'b0; clkEn = 1'b0;
        step();
        load = 1'b0; en = 1'b1; clkEn = 1'b1;
        step();
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_done: got %b expected 1", done); end
        load = 1'b1; loadVal = 8'h04;
        step();
        load = 1'b0;
        vectors++;
        if (count !== 8'h04) begin miscompares++; $display("[TB] FAIL b2b_reload: got %h expected 04", count); end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_busy: got %b expected 1", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_done_low: got %b expected 0", done); end
        load = 1'b1; loadVal = 8'h00;
        step();
        load = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_preset_busy: got %b expected 0", busy); end
        step();
        vectors++;
        if (count !== 8'h00) begin miscompares++; $display("[TB] FAIL zero_preset_count: got %h expected 00", count); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_preset_done: got %b expected 0", done); end
        en = 1'b0; clkEn = 1'b0;
    endtask

    task automatic test_async_reset();
        load = 1'b1; loadVal = 8'h09; en = 1'b0; clkEn = 1'b0;
        step();
        load = 1'b0; en = 1'b1; clkEn = 1'b1;
        step();
        step();
        vectors++;
        if (count !== 8'h07) begin miscompares++; $display("[TB] FAIL pre_reset: got %h expected 07", count); end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (count !== 8'h00) begin miscompares++; $display("[TB] FAIL async_count: got %h expected 00", count); end
        vectors++;
        if (bo !== 1'b1) begin miscompares++; $display("[TB] FAIL async_bo: got %b expected 1", bo); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL async_busy: got %b expected 0", busy); end
        en = 1'b0; clkEn = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        load = 1'b1; loadVal = 8'h15;
        step();
        load = 1'b0;
        vectors++;
        if (count !== 8'h15) begin miscompares++; $display("[TB] FAIL load_after_reset: got %h expected 15", count); end
    endtask

`ifdef BCD_DOWN_RELOAD_EN
    task automatic test_reload();
        logic [7:0] expSeq  [7] = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02, 8'h01};
        logic       expDone [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        load = 1'b1; loadVal = 8'h02; en = 1'b0; clkEn = 1'b0;
        step();
        load = 1'b0; en = 1'b1; clkEn = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            vectors++;
            if (count !== expSeq[i]) begin
                miscompares++;
                $display("[TB] FAIL reload_count_%0d: got %h expected %h", i, count, expSeq[i]);
            end
            vectors++;
            if (done !== expDone[i]) begin
                miscompares++;
                $display("[TB] FAIL reload_done_%0d: got %b expected %b", i, done, expDone[i]);
            end
        end
        en = 1'b0; clkEn = 1'b0;
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        $display("[TB] starting bcd_down_counter checks");
        test_reset();
        test_countdown();
        test_clamp();
        test_load_priority();
        test_clken_gate();
        test_back_to_back();
        test_async_reset();
`ifdef BCD_DOWN_RELOAD_EN
        test_reload();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
